draw_image: RTL

DRAW_IMAGE -- requirements
Module: draw_image

---
 rtl/draw_image_pkg.sv | 38 +++
 rtl/draw_image_delay.sv | 30 +++
 rtl/draw_image.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/draw_image_pkg.sv
// Shared VGA constants, the timing/pixel bus payload and a window-span helper
// used by the image overlay (draw_image) and its alignment delay line.
package draw_image_pkg;

  localparam int unsigned HCNT_W    = 11;            // hcount/vcount width
  localparam int unsigned RGB_W     = 12;            // 4:4:4 colour width
  localparam int unsigned AXIS_W    = 6;             // image ROM address bits per axis
  localparam int unsigned ADDR_W    = 2 * AXIS_W;    // image ROM address width
  localparam int unsigned SPAN_W    = HCNT_W + 1;    // one spare bit so lo+len cannot wrap
  localparam int unsigned IMG_W_DEF = 48;
  localparam int unsigned IMG_H_DEF = 64;
  localparam logic [RGB_W-1:0] KEY_RGB_DEF = 12'hF0F;

  // Timing strobes and background pixel travelling alongside the ROM lookup
  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;

  localparam int unsigned VGA_BUS_W = $bits(vga_bus_t);

  // lo <= pos < lo + len, evaluated one bit wider than the counters
  function automatic logic in_span(input logic [HCNT_W-1:0] pos,
                                   input logic [HCNT_W-1:0] lo,
                                   input logic [SPAN_W-1:0] len);
    logic [SPAN_W-1:0] pos_w;
    logic [SPAN_W-1:0] lo_w;
    pos_w = {1'b0, pos};
    lo_w  = {1'b0, lo};
    return (pos_w >= lo_w) && (pos_w < SPAN_W'(lo_w + len));
  endfunction

endpackage

// File: rtl/draw_image_delay.sv
// delay: fixed-latency shift register used to align side-band data with the
// image ROM read.
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   din_i      : WIDTH-bit data in
//   dout_o     : din_i delayed by CLK_DEL clocks (CLK_DEL >= 1)
module draw_image_delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  // Shift chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_image.sv
// draw_image: overlays an IMG_W x IMG_H image from an external ROM onto the
// VGA stream at a per-frame position, with KEY_RGB treated as transparent.
//   clk, rst                  : pixel clock, asynchronous active-low reset
//   hcount/vcount/h,vsync/
//   h,vblnk/rgb _in           : incoming timing and background pixel
//   xpos, ypos                : requested top-left corner, sampled at vblank start
//   pixel_addr                : ROM address {dy[5:0], dx[5:0]}, 0 outside the image
//   rgb_pixel                 : ROM data, one clock after pixel_addr
//   *_out                     : timing and composed pixel, 3 clocks after the inputs
module draw_image
  import draw_image_pkg::*;
#(
  parameter int unsigned      IMG_W   = IMG_W_DEF,
  parameter int unsigned      IMG_H   = IMG_H_DEF,
  parameter logic [RGB_W-1:0] KEY_RGB = KEY_RGB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [HCNT_W-1:0] vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [HCNT_W-1:0] xpos,
  input  logic [HCNT_W-1:0] ypos,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [RGB_W-1:0]  rgb_pixel,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [HCNT_W-1:0] vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  logic              vblnk_q;
  logic [HCNT_W-1:0] x_lat_q, x_lat_d;
  logic [HCNT_W-1:0] y_lat_q, y_lat_d;
  logic              in_win_q, in_win_d;
  logic [ADDR_W-1:0] pixel_addr_d;
  logic [AXIS_W-1:0] dx, dy;
  logic              in_win_dly;
  vga_bus_t          bus_in, bus_dly;
  logic [RGB_W-1:0]  rgb_d;

  // Position latch (vblank rising edge only) and stage-1 address/window
  always_comb begin
    x_lat_d = x_lat_q;
    y_lat_d = y_lat_q;
    if (vblnk_in && !vblnk_q) begin
      x_lat_d = xpos;
      y_lat_d = ypos;
    end
    // Low address bits of the offset only depend on the low counter bits
    dx = AXIS_W'(hcount_in[AXIS_W-1:0] - x_lat_q[AXIS_W-1:0]);
    dy = AXIS_W'(vcount_in[AXIS_W-1:0] - y_lat_q[AXIS_W-1:0]);
    in_win_d = in_span(hcount_in, x_lat_q, SPAN_W'(IMG_W)) &&
               in_span(vcount_in, y_lat_q, SPAN_W'(IMG_H));
    pixel_addr_d = in_win_d ? {dy, dx} : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q    <= 1'b0;
      x_lat_q    <= '0;
      y_lat_q    <= '0;
      in_win_q   <= 1'b0;
      pixel_addr <= '0;
    end else begin
      vblnk_q    <= vblnk_in;
      x_lat_q    <= x_lat_d;
      y_lat_q    <= y_lat_d;
      in_win_q   <= in_win_d;
      pixel_addr <= pixel_addr_d;
    end
  end

  // Side-band bundle reaches the output register together with rgb_pixel
  always_comb begin
    bus_in.hcount = hcount_in;
    bus_in.vcount = vcount_in;
    bus_in.hsync  = hsync_in;
    bus_in.vsync  = vsync_in;
    bus_in.hblnk  = hblnk_in;
    bus_in.vblnk  = vblnk_in;
    bus_in.rgb    = rgb_in;
  end

  draw_image_delay #(
    .WIDTH  (VGA_BUS_W),
    .CLK_DEL(2)
  ) u_bus_dly (
    .clk   (clk),
    .rst_n (rst),
    .din_i (bus_in),
    .dout_o(bus_dly)
  );

  draw_image_delay #(
    .WIDTH  (1),
    .CLK_DEL(1)
  ) u_win_dly (
    .clk   (clk),
    .rst_n (rst),
    .din_i (in_win_q),
    .dout_o(in_win_dly)
  );

  // Blanking wins, then opaque image pixels, then background
  always_comb begin
    rgb_d = bus_dly.rgb;
    if (bus_dly.hblnk || bus_dly.vblnk) begin
      rgb_d = '0;
    end else if (in_win_dly && (rgb_pixel != KEY_RGB)) begin
      rgb_d = rgb_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= bus_dly.hcount;
      vcount_out <= bus_dly.vcount;
      hsync_out  <= bus_dly.hsync;
      vsync_out  <= bus_dly.vsync;
      hblnk_out  <= bus_dly.hblnk;
      vblnk_out  <= bus_dly.vblnk;
      rgb_out    <= rgb_d;
    end
  end

endmodule
